// File: rtl/p2s_tx_if.sv
// Handshake and serial-output bundle for p2s_tx.
// The source (master) drives the parallel word; the transmitter (slave) drives the serial link.
interface p2s_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic             serial_o;
    logic             serial_vld_o;
    logic             last_o;

    modport master (
        output data_i,
        output valid_i,
        input  ready_o,
        input  serial_o,
        input  serial_vld_o,
        input  last_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o,
        output serial_o,
        output serial_vld_o,
        output last_o
    );
endinterface

// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter, LSB first, with frame-bit qualifier and last-bit flag.
// Define P2S_PARITY_EN to append an even-parity bit after the data bits.
module p2s_tx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic    clk,
    input  logic    reset,
    p2s_tx_if.slave bus
);

`ifdef P2S_PARITY_EN
    localparam int unsigned FrameLen = WIDTH + 1;
`else
    localparam int unsigned FrameLen = WIDTH;
`endif
    localparam int unsigned   CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(FrameLen - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [FrameLen-1:0] sh_q, sh_d;
    logic [FrameLen-1:0] frame;
    logic                serial_q, serial_d;
    logic                vld_q, vld_d;
    logic                last_q, last_d;
    logic                at_last;
    logic                ready;
    logic                accept;

`ifdef P2S_PARITY_EN
    assign frame = {^bus.data_i, bus.data_i};
`else
    assign frame = bus.data_i;
`endif

    // ready depends only on state and counter, never on valid_i
    assign at_last = (state_q == StShift) && (cnt_q == LastIdx);
    assign ready   = (state_q == StIdle) || at_last;
    assign accept  = bus.valid_i && ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sh_q     <= '0;
            serial_q <= 1'b0;
            vld_q    <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            serial_q <= serial_d;
            vld_q    <= vld_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StShift;
            StShift: if (at_last && !accept) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // sh_q holds the frame bits still waiting to reach serial_o
    always_comb begin
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        serial_d = 1'b0;
        vld_d    = 1'b0;
        last_d   = 1'b0;
        if (accept) begin
            sh_d     = frame >> 1;
            serial_d = frame[0];
            cnt_d    = '0;
            vld_d    = 1'b1;
            last_d   = (LastIdx == '0);
        end else if ((state_q == StShift) && !at_last) begin
            sh_d     = sh_q >> 1;
            serial_d = sh_q[0];
            cnt_d    = cnt_q + 1'b1;
            vld_d    = 1'b1;
            last_d   = (cnt_d == LastIdx);
        end
    end

    assign bus.ready_o      = ready;
    assign bus.serial_o     = serial_q;
    assign bus.serial_vld_o = vld_q;
    assign bus.last_o       = last_q;

endmodule

// File: tb/tb_p2s_tx.sv
// Self-checking bench for p2s_tx: per-cycle queue model of the serial stream plus
// hand-computed frame literals.
module tb_p2s_tx;
    localparam int unsigned W = 8;
`ifdef P2S_PARITY_EN
    localparam int unsigned N = W + 1;
`else
    localparam int unsigned N = W;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    p2s_tx_if #(.WIDTH(W)) bus ();
    p2s_tx #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of (bit, last) entries still to appear on the line; front = current cycle
    int   q_bit[$];
    int   q_last[$];
    bit   armed = 1'b0;
    logic m_acc;
    int   m_b;

    always @(posedge clk) begin
        if (reset) begin
            q_bit.delete();
            q_last.delete();
            armed = 1'b1;
        end else if (armed) begin
            m_acc = bus.valid_i && (q_bit.size() <= 1);
            if (q_bit.size() > 0) begin
                void'(q_bit.pop_front());
                void'(q_last.pop_front());
            end
            if (m_acc) begin
                for (int i = 0; i < int'(N); i++) begin
                    if (i < int'(W)) m_b = int'(bus.data_i[i]);
                    else m_b = $countones(bus.data_i) % 2;
                    q_bit.push_back(m_b);
                    q_last.push_back((i == int'(N) - 1) ? 1 : 0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            if (q_bit.size() > 0) begin
                check("serial_vld_o", 64'(bus.serial_vld_o), 64'd1);
                check("serial_o", 64'(bus.serial_o), 64'(q_bit[0]));
                check("last_o", 64'(bus.last_o), 64'(q_last[0]));
            end else begin
                check("serial_vld_o", 64'(bus.serial_vld_o), 64'd0);
                check("serial_o", 64'(bus.serial_o), 64'd0);
                check("last_o", 64'(bus.last_o), 64'd0);
            end
            check("ready_o", 64'(bus.ready_o), (q_bit.size() <= 1) ? 64'd1 : 64'd0);
        end
    end

    // Log of every frame bit seen on the line, in order
    logic cap_log [0:4095];
    int   cap_n = 0;

    always @(posedge clk) begin
        #1;
        if (bus.serial_vld_o === 1'b1 && cap_n < 4096) begin
            cap_log[cap_n] = bus.serial_o;
            cap_n++;
        end
    end

    task automatic send(input logic [W-1:0] d);
        int n;
        n = 0;
        bus.data_i  = d;
        bus.valid_i = 1'b1;
        while (bus.ready_o !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check("send_timeout", 64'd1, 64'd0);
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    task automatic expect_stream(input string name, input int start, input logic [63:0] exp,
                                 input int len);
        logic [63:0] v;
        v = '0;
        check({name, "_len"}, 64'(cap_n - start), 64'(len));
        for (int i = 0; i < len && i < 64; i++) begin
            if (start + i < cap_n) v[i] = cap_log[start + i];
        end
        check(name, v, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, expected finish");
        $fatal(1);
    end

    int start;

    initial begin
        reset       = 1'b1;
        bus.valid_i = 1'b1;
        bus.data_i  = 8'hFF;
        repeat (3) @(negedge clk);
        reset       = 1'b0;
        bus.valid_i = 1'b0;
        check("ready_after_reset", 64'(bus.ready_o), 64'd1);
        check("vld_after_reset", 64'(bus.serial_vld_o), 64'd0);
        repeat (2) @(negedge clk);

        // single frame
        start = cap_n;
        send(8'hA5);
        repeat (N + 2) @(negedge clk);
`ifdef P2S_PARITY_EN
        expect_stream("frame_a5", start, 64'h0A5, 9);
`else
        expect_stream("frame_a5", start, 64'hA5, 8);
`endif

        // back-to-back
        start = cap_n;
        send(8'h0F);
        send(8'hF0);
        repeat (N + 2) @(negedge clk);
`ifdef P2S_PARITY_EN
        expect_stream("b2b_0f_f0", start, 64'h1E00F, 18);
`else
        expect_stream("b2b_0f_f0", start, 64'hF00F, 16);
`endif

        // backpressure with data_i changing mid-frame
        start = cap_n;
        send(8'h81);
        @(negedge clk);
        send(8'h3C);
        repeat (N + 2) @(negedge clk);
`ifdef P2S_PARITY_EN
        expect_stream("bp_81_3c", start, 64'h7881, 18);
`else
        expect_stream("bp_81_3c", start, 64'h3C81, 16);
`endif

        // reset mid-frame
        send(8'hFF);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("vld_after_mid_reset", 64'(bus.serial_vld_o), 64'd0);
        check("ready_after_mid_reset", 64'(bus.ready_o), 64'd1);
        reset = 1'b0;
        start = cap_n;
        send(8'h01);
        repeat (N + 2) @(negedge clk);
`ifdef P2S_PARITY_EN
        expect_stream("after_reset_01", start, 64'h101, 9);
`else
        expect_stream("after_reset_01", start, 64'h01, 8);
`endif

        start = cap_n;
        send(8'h07);
        repeat (N + 2) @(negedge clk);
`ifdef P2S_PARITY_EN
        expect_stream("frame_07", start, 64'h107, 9);
`else
        expect_stream("frame_07", start, 64'h07, 8);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/p2s_tx.md
# p2s_tx

Parallel-to-serial transmitter. Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock, LSB first. Marks each active bit with a qualifier and flags the final bit. It is the transmit end of the single-bit serial link used across the day-series blocks, and drives the serial data input of a downstream flop or receiver.

## Interface
- WIDTH, 8, data word width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; sampled on rising clk.
- data_i  input  WIDTH  parallel word to transmit; sampled only on accept.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  block can accept a word this cycle.
- serial_o  output  1  current serial bit.
- serial_vld_o  output  1  serial_o carries a frame bit this cycle.
- last_o  output  1  current bit is the final bit of the frame.

## Operation
- Accept: valid_i && ready_o at a rising clk edge. data_i is captured into the shift register and the bit counter is cleared.
- States:
  - IDLE: ready_o=1, serial_vld_o=0.
  - SHIFT: serial_vld_o=1.
- Transitions:
  - IDLE -> SHIFT on accept.
  - SHIFT -> IDLE after the last frame bit if there is no accept.
  - SHIFT -> SHIFT on the last bit if there is an accept (back-to-back frames).
- Frame length N = WIDTH. With parity enabled, N = WIDTH+1.
- Bit order: data bit 0 first, then bit WIDTH-1 last. The parity bit, if enabled, follows the data bits.
- ready_o=1 in IDLE, and also during the last bit of SHIFT. It is 0 for all other SHIFT cycles.
- last_o=1 only in the SHIFT cycle carrying bit N-1.
- serial_o=0 whenever serial_vld_o=0.
- Bit counter width: $clog2(WIDTH+1). It counts 0..N-1 with no wrap beyond N-1.
- valid_i with ready_o=0 is ignored. No word is lost as long as the source holds valid_i until accept.
- data_i changing mid-frame has no effect on the frame in flight.
- reset asserted mid-frame: the frame is abandoned at that edge. There is no partial completion.
- valid_i during reset is ignored. The first accept can occur on the first edge at which reset=0.

## Timing
- Reset values (all registered outputs): serial_o=0, serial_vld_o=0, last_o=0, state=IDLE. ready_o=1 from the first cycle after reset.
- Latency: bit 0 appears on serial_o in the cycle immediately after the accept edge, as a registered output.
- A frame occupies exactly N consecutive cycles.
- Throughput: with valid_i held high, frames run back-to-back with no idle cycle. Sustained rate is one word per N cycles.
- All outputs are registered except ready_o, which is decoded from state and counter with no path from valid_i.

## Configuration
- P2S_PARITY_EN:
  - When defined, one even-parity bit (XOR of all WIDTH data bits) is appended after bit WIDTH-1. N = WIDTH+1, and last_o marks the parity bit.
  - When undefined, no parity logic is built, N = WIDTH, and last_o marks data bit WIDTH-1.

## Test plan
- Reset behaviour: hold reset=1 for 3 cycles with valid_i=1 and data_i=8'hFF -> serial_vld_o=0 and serial_o=0 throughout; ready_o=1 after release.
- Single frame: accept 8'hA5 -> serial_o = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept; serial_vld_o high for exactly 8 cycles; last_o on the 8th; ready_o high only on the 8th.
- Back-to-back: valid_i held with 8'h0F then 8'hF0 -> 16 contiguous valid bits: 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1; no gap between frames.
- Backpressure and mid-frame change: assert valid_i on frame cycle 3 with 8'h3C while 8'h81 is shifting -> 8'h81 completes unaltered; 8'h3C is accepted on the last-bit edge and follows immediately.
- Reset mid-frame: reset=1 on cycle 4 of 8'hFF -> serial_vld_o=0 the next cycle; a new accept of 8'h01 after release gives 1,0,0,0,0,0,0,0.
- Parity (P2S_PARITY_EN defined): 8'hA5 -> 9 bits ending with parity 0; 8'h07 -> 9 bits ending with parity 1; last_o on the 9th bit.
